// File: rtl/sfif_cpl_resp.sv
// PCIe completer for the SFIF loopback path: MWr32 into a 16-DW register file, MRd32 answered with CplD.
// Optional build macro SFIF_CPL_UR_EN: answer unsupported-length MRd with a Cpl UR instead of dropping it.
module sfif_cpl_resp #(
  parameter logic [15:0] CPL_ID    = 16'h0100,
  parameter int          MAX_RD_DW = 4
) (
  input  logic        clk_125,
  input  logic        rst,
  input  logic        rx64_st,
  input  logic        rx64_end,
  input  logic        rx64_dwen,
  input  logic [63:0] rx64_data,
  input  logic        cr_avail,
  output logic        tx_req,
  input  logic        tx_rdy,
  input  logic        tx_val,
  output logic        tx_st,
  output logic        tx_end,
  output logic        tx_dwen,
  output logic [63:0] tx_data,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SEND} state_t;
  typedef enum logic [1:0] {RX_NONE, RX_MRD, RX_MWR} rx_kind_t;

  typedef struct packed {
    logic        ur;
    logic [15:0] reqid;
    logic [7:0]  tag;
    logic [6:0]  addr;
    logic [9:0]  len;
  } req_t;

  // Receive-side capture
  logic        rx_active;
  logic        rx_second;
  rx_kind_t    rx_kind;
  logic [9:0]  rx_len;
  logic [15:0] rx_reqid;
  logic [7:0]  rx_tag;
  logic [3:0]  rx_fbe;
  logic [6:0]  rx_addr;
  logic [31:0] rx_d0;

  logic [6:0]  cur_addr;
  logic [31:0] cur_d0;
  logic        tlp_done;
  logic        len_ok_rd;
  logic        mwr_fire;
  logic        mwr_drop;
  logic        mrd_ok;
  logic        mrd_ur;
  logic        mrd_drop;

  // Request FIFO and push stage
  logic        push_vld;
  req_t        push_entry;
  req_t        fifo_mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  fifo_cnt;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic        full_drop;

  logic [31:0] reg_file [16];

  // Completion FSM
  state_t      state, state_n;
  logic [1:0]  beat, beat_n;
  logic        load;
  logic        clear;

  req_t        head;
  logic [1:0]  last_beat;
  logic        dwen_last;
  logic [31:0] dw0, dw1, dw2;
  logic [3:0]  idx0, idx1, idx2, idx3;
  logic [63:0] beat_data;

  logic [1:0]  drop_inc;
  logic [8:0]  drop_sum;

  logic        unused_bits;
  assign unused_bits = &{1'b0, rx64_dwen, rx64_data[55:42], rx64_data[7:4]};

  // The end beat may also be the address beat, so take addr/data0 straight from the bus then.
  assign cur_addr  = rx_second ? rx64_data[38:32] : rx_addr;
  assign cur_d0    = rx_second ? rx64_data[31:0]  : rx_d0;
  assign tlp_done  = rx_active && !rx64_st && rx64_end;
  assign len_ok_rd = (rx_len != 10'd0) && (rx_len <= 10'(MAX_RD_DW));
  assign mwr_fire  = tlp_done && (rx_kind == RX_MWR) && (rx_len == 10'd1);
  assign mwr_drop  = tlp_done && (rx_kind == RX_MWR) && (rx_len != 10'd1);
  assign mrd_ok    = tlp_done && (rx_kind == RX_MRD) && len_ok_rd;
`ifdef SFIF_CPL_UR_EN
  assign mrd_ur    = tlp_done && (rx_kind == RX_MRD) && !len_ok_rd;
  assign mrd_drop  = 1'b0;
`else
  assign mrd_ur    = 1'b0;
  assign mrd_drop  = tlp_done && (rx_kind == RX_MRD) && !len_ok_rd;
`endif

  always_ff @(posedge clk_125 or posedge rst) begin
    if (rst) begin
      rx_active <= 1'b0;
      rx_second <= 1'b0;
      rx_kind   <= RX_NONE;
      rx_len    <= '0;
      rx_reqid  <= '0;
      rx_tag    <= '0;
      rx_fbe    <= '0;
      rx_addr   <= '0;
      rx_d0     <= '0;
    end else if (rx64_st) begin
      rx_active <= !rx64_end;
      rx_second <= !rx64_end;
      case (rx64_data[63:56])
        8'h00:   rx_kind <= RX_MRD;
        8'h40:   rx_kind <= RX_MWR;
        default: rx_kind <= RX_NONE;
      endcase
      rx_len   <= rx64_data[41:32];
      rx_reqid <= rx64_data[31:16];
      rx_tag   <= rx64_data[15:8];
      rx_fbe   <= rx64_data[3:0];
    end else if (rx_active) begin
      if (rx_second) begin
        rx_addr   <= rx64_data[38:32];
        rx_d0     <= rx64_data[31:0];
        rx_second <= 1'b0;
      end
      if (rx64_end) begin
        rx_active <= 1'b0;
      end
    end
  end

  // One-cycle push stage; the full check happens here, so a same-cycle pop cannot make room.
  always_ff @(posedge clk_125 or posedge rst) begin
    if (rst) begin
      push_vld   <= 1'b0;
      push_entry <= '0;
    end else begin
      push_vld   <= mrd_ok || mrd_ur;
      push_entry <= '{ur: mrd_ur, reqid: rx_reqid, tag: rx_tag, addr: cur_addr, len: rx_len};
    end
  end

  always_ff @(posedge clk_125 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        reg_file[i] <= '0;
      end
    end else if (mwr_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (rx_fbe[b]) begin
          reg_file[cur_addr[5:2]][8*b +: 8] <= cur_d0[8*b +: 8];
        end
      end
    end
  end

  assign fifo_full = (fifo_cnt == 2'd2);
  assign push      = push_vld && !fifo_full;
  assign full_drop = push_vld && fifo_full;

  always_ff @(posedge clk_125 or posedge rst) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_entry;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign drop_inc = {1'b0, mwr_drop} + {1'b0, mrd_drop} + {1'b0, full_drop};
  assign drop_sum = {1'b0, drop_cnt} + {7'd0, drop_inc};

  always_ff @(posedge clk_125 or posedge rst) begin
    if (rst) begin
      drop_cnt <= 8'd0;
    end else begin
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

  always_comb begin
    state_n = state;
    beat_n  = beat;
    pop     = 1'b0;
    load    = 1'b0;
    clear   = 1'b0;
    case (state)
      S_IDLE: begin
        if (fifo_cnt != 2'd0) begin
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        if (tx_rdy && cr_avail) begin
          state_n = S_SEND;
          beat_n  = 2'd0;
          load    = 1'b1;
        end
      end
      S_SEND: begin
        if (tx_val) begin
          if (beat == last_beat) begin
            state_n = S_IDLE;
            pop     = 1'b1;
            clear   = 1'b1;
          end else begin
            beat_n = beat + 2'd1;
            load   = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Completion header and data for the beat about to be presented, built from the FIFO head.
  always_comb begin
    head      = fifo_mem[rd_ptr];
    idx0      = head.addr[5:2];
    idx1      = idx0 + 4'd1;
    idx2      = idx0 + 4'd2;
    idx3      = idx0 + 4'd3;
    dwen_last = head.ur ? 1'b1 : !head.len[0];
    if (head.ur) begin
      last_beat = 2'd1;
    end else begin
      case (head.len)
        10'd1:        last_beat = 2'd1;
        10'd2, 10'd3: last_beat = 2'd2;
        default:      last_beat = 2'd3;
      endcase
    end
    if (head.ur) begin
      dw0 = {8'h0A, 24'd0};
      dw1 = {CPL_ID, 3'b001, 1'b0, 12'd4};
    end else begin
      dw0 = {8'h4A, 14'd0, head.len};
      dw1 = {CPL_ID, 3'b000, 1'b0, head.len, 2'b00};
    end
    dw2 = {head.reqid, head.tag, 1'b0, head.addr};
    case (beat_n)
      2'd0:    beat_data = {dw0, dw1};
      2'd1:    beat_data = {dw2, reg_file[idx0]};
      2'd2:    beat_data = {reg_file[idx1], reg_file[idx2]};
      default: beat_data = {reg_file[idx3], 32'd0};
    endcase
    if ((beat_n == last_beat) && dwen_last) begin
      beat_data[31:0] = 32'd0;
    end
  end

  always_ff @(posedge clk_125 or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      beat    <= 2'd0;
      tx_st   <= 1'b0;
      tx_end  <= 1'b0;
      tx_dwen <= 1'b0;
      tx_data <= 64'd0;
    end else begin
      state <= state_n;
      beat  <= beat_n;
      if (load) begin
        tx_st   <= (beat_n == 2'd0);
        tx_end  <= (beat_n == last_beat);
        tx_dwen <= (beat_n == last_beat) && dwen_last;
        tx_data <= beat_data;
      end else if (clear) begin
        tx_st   <= 1'b0;
        tx_end  <= 1'b0;
        tx_dwen <= 1'b0;
        tx_data <= 64'd0;
      end
    end
  end

  assign tx_req = (state == S_REQ);
  assign busy   = (fifo_cnt != 2'd0) || (state != S_IDLE);

endmodule

// File: tb/tb_sfif_cpl_resp.sv
// Directed self-checking bench for sfif_cpl_resp; expectations follow SFIF_CPL_UR_EN when defined.
module tb_sfif_cpl_resp;

  logic        clk_125 = 1'b0;
  logic        rst;
  logic        rx64_st, rx64_end, rx64_dwen;
  logic [63:0] rx64_data;
  logic        cr_avail;
  logic        tx_req, tx_rdy, tx_val;
  logic        tx_st, tx_end, tx_dwen;
  logic [63:0] tx_data;
  logic        busy;
  logic [7:0]  drop_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_drop     = 0;
  int req_seen;
  logic found;

  sfif_cpl_resp dut (
    .clk_125  (clk_125),
    .rst      (rst),
    .rx64_st  (rx64_st),
    .rx64_end (rx64_end),
    .rx64_dwen(rx64_dwen),
    .rx64_data(rx64_data),
    .cr_avail (cr_avail),
    .tx_req   (tx_req),
    .tx_rdy   (tx_rdy),
    .tx_val   (tx_val),
    .tx_st    (tx_st),
    .tx_end   (tx_end),
    .tx_dwen  (tx_dwen),
    .tx_data  (tx_data),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  always #4 clk_125 = ~clk_125;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic en, input logic dw, input logic [63:0] data);
    @(negedge clk_125);
    rx64_st   = st;
    rx64_end  = en;
    rx64_dwen = dw;
    rx64_data = data;
  endtask

  task automatic rxIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic sendMwr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    applyStimulus(1'b1, 1'b0, 1'b0, {8'h40, 14'd0, 10'd1, 16'h0000, 8'h00, 4'h0, be});
    applyStimulus(1'b0, 1'b1, 1'b0, {addr, data});
    rxIdle();
  endtask

  task automatic sendMrd(input logic [31:0] addr, input logic [9:0] len, input logic [7:0] tag,
                         input logic [15:0] reqid);
    applyStimulus(1'b1, 1'b0, 1'b0, {8'h00, 14'd0, len, reqid, tag, 8'h0F});
    applyStimulus(1'b0, 1'b1, 1'b1, {addr, 32'd0});
    rxIdle();
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_125);
  endtask

  // Accept one completion, checking every beat; optionally hold tx_val low on one beat.
  task automatic collectCpl(input string tag, input int nbeats,
                            input logic [63:0] b0, input logic [63:0] b1,
                            input logic [63:0] b2, input logic [63:0] b3,
                            input logic exp_dwen, input int stall_beat, input int stall_cycles);
    logic [63:0] exp_beats [4];
    logic        seen;
    exp_beats[0] = b0;
    exp_beats[1] = b1;
    exp_beats[2] = b2;
    exp_beats[3] = b3;
    seen   = 1'b0;
    tx_val = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_125);
      if (tx_st === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput({tag, " start"}, {63'd0, seen}, 64'd1);
    if (seen) begin
      for (int k = 0; k < nbeats; k++) begin
        if (k > 0) @(negedge clk_125);
        checkOutput($sformatf("%s beat%0d data", tag, k), tx_data, exp_beats[k]);
        checkOutput($sformatf("%s beat%0d st", tag, k), {63'd0, tx_st}, {63'd0, k == 0});
        checkOutput($sformatf("%s beat%0d end", tag, k), {63'd0, tx_end}, {63'd0, k == nbeats - 1});
        if (k == nbeats - 1) begin
          checkOutput($sformatf("%s dwen", tag), {63'd0, tx_dwen}, {63'd0, exp_dwen});
        end
        if (k == stall_beat) begin
          tx_val = 1'b0;
          for (int s = 0; s < stall_cycles; s++) begin
            @(negedge clk_125);
            checkOutput($sformatf("%s hold%0d", tag, s), tx_data, exp_beats[k]);
          end
          tx_val = 1'b1;
        end
      end
      @(negedge clk_125);
    end
    tx_val = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    rx64_st   = 1'b0;
    rx64_end  = 1'b0;
    rx64_dwen = 1'b0;
    rx64_data = 64'd0;
    cr_avail  = 1'b1;
    tx_rdy    = 1'b1;
    tx_val    = 1'b0;
    waitCycles(3);
    checkOutput("reset tx_req", {63'd0, tx_req}, 64'd0);
    checkOutput("reset tx_st", {63'd0, tx_st}, 64'd0);
    checkOutput("reset tx_end", {63'd0, tx_end}, 64'd0);
    checkOutput("reset tx_dwen", {63'd0, tx_dwen}, 64'd0);
    checkOutput("reset tx_data", tx_data, 64'd0);
    checkOutput("reset busy", {63'd0, busy}, 64'd0);
    checkOutput("reset drop_cnt", {56'd0, drop_cnt}, 64'd0);
    rst = 1'b0;
    waitCycles(2);

    // Single-DW write then read back
    sendMwr(32'h10, 32'hDEADBEEF, 4'hF);
    sendMrd(32'h10, 10'd1, 8'h05, 16'h0000);
    collectCpl("rd1", 2, 64'h4A000001_01000004, 64'h00000510_DEADBEEF, 64'd0, 64'd0, 1'b0, -1, 0);

    // Partial byte enables
    sendMwr(32'h10, 32'h11223344, 4'b0101);
    sendMrd(32'h10, 10'd1, 8'h07, 16'h0000);
    collectCpl("be", 2, 64'h4A000001_01000004, 64'h00000710_DE22BE44, 64'd0, 64'd0, 1'b0, -1, 0);

    // Length-4 read wrapping from index 15 to 0
    sendMwr(32'h3C, 32'h1, 4'hF);
    sendMwr(32'h00, 32'h2, 4'hF);
    sendMwr(32'h04, 32'h3, 4'hF);
    sendMwr(32'h08, 32'h4, 4'hF);
    sendMrd(32'h3C, 10'd4, 8'h06, 16'h1234);
    collectCpl("len4", 4, 64'h4A000004_01000010, 64'h1234063C_00000001,
               64'h00000002_00000003, 64'h00000004_00000000, 1'b1, -1, 0);

    sendMrd(32'h00, 10'd2, 8'h0A, 16'h0000);
    collectCpl("len2", 3, 64'h4A000002_01000008, 64'h00000A00_00000002,
               64'h00000003_00000000, 64'd0, 1'b1, -1, 0);
    sendMrd(32'h00, 10'd3, 8'h09, 16'h0000);
    collectCpl("len3", 3, 64'h4A000003_0100000C, 64'h00000900_00000002,
               64'h00000003_00000004, 64'd0, 1'b0, -1, 0);

    // Three reads while the TX side is not granting: third one is dropped
    tx_rdy = 1'b0;
    sendMrd(32'h04, 10'd1, 8'h11, 16'h0000);
    sendMrd(32'h04, 10'd1, 8'h12, 16'h0000);
    sendMrd(32'h04, 10'd1, 8'h13, 16'h0000);
    exp_drop = exp_drop + 1;
    waitCycles(4);
    checkOutput("full tx_req", {63'd0, tx_req}, 64'd1);
    checkOutput("full busy", {63'd0, busy}, 64'd1);
    checkOutput("full drop_cnt", {56'd0, drop_cnt}, 64'(exp_drop));
    tx_rdy = 1'b1;
    collectCpl("q0", 2, 64'h4A000001_01000004, 64'h00001104_00000003, 64'd0, 64'd0, 1'b0, -1, 0);
    collectCpl("q1", 2, 64'h4A000001_01000004, 64'h00001204_00000003, 64'd0, 64'd0, 1'b0, -1, 0);
    waitCycles(8);
    checkOutput("queue drained busy", {63'd0, busy}, 64'd0);

    // tx_val stall on beat 1
    sendMrd(32'h3C, 10'd4, 8'h40, 16'hABCD);
    collectCpl("stall", 4, 64'h4A000004_01000010, 64'hABCD403C_00000001,
               64'h00000002_00000003, 64'h00000004_00000000, 1'b1, 1, 5);

    // Unsupported read length
    sendMrd(32'h10, 10'd8, 8'h20, 16'h0000);
`ifdef SFIF_CPL_UR_EN
    collectCpl("ur", 2, 64'h0A000000_01002004, 64'h00002010_00000000, 64'd0, 64'd0, 1'b1, -1, 0);
`else
    exp_drop = exp_drop + 1;
    req_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_125);
      if (tx_req === 1'b1) req_seen++;
    end
    checkOutput("unsupported no tx", 64'(req_seen), 64'd0);
`endif
    checkOutput("unsupported drop_cnt", {56'd0, drop_cnt}, 64'(exp_drop));

    // MWr of length 2 is dropped and leaves the register untouched
    applyStimulus(1'b1, 1'b0, 1'b0, {8'h40, 14'd0, 10'd2, 16'h0000, 8'h00, 4'hF, 4'hF});
    applyStimulus(1'b0, 1'b0, 1'b0, {32'h10, 32'h55555555});
    applyStimulus(1'b0, 1'b1, 1'b1, {32'h66666666, 32'd0});
    rxIdle();
    exp_drop = exp_drop + 1;
    waitCycles(2);
    checkOutput("mwr len2 drop_cnt", {56'd0, drop_cnt}, 64'(exp_drop));
    sendMrd(32'h10, 10'd1, 8'h21, 16'h0000);
    collectCpl("mwr len2 keep", 2, 64'h4A000001_01000004, 64'h00002110_DE22BE44, 64'd0, 64'd0, 1'b0, -1, 0);

    // Single-beat TLP with start and end together is ignored without counting
    applyStimulus(1'b1, 1'b1, 1'b0, {8'h00, 14'd0, 10'd1, 16'h0000, 8'h22, 8'h0F});
    rxIdle();
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_125);
      if (tx_req === 1'b1) req_seen++;
    end
    checkOutput("malformed no tx", 64'(req_seen), 64'd0);
    checkOutput("malformed drop_cnt", {56'd0, drop_cnt}, 64'(exp_drop));

    // Reset in the middle of a completion
    sendMrd(32'h10, 10'd1, 8'h30, 16'h0000);
    found  = 1'b0;
    tx_val = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_125);
      if (tx_st === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("rst start", {63'd0, found}, 64'd1);
    @(negedge clk_125);
    checkOutput("rst beat1 end", {63'd0, tx_end}, 64'd1);
    rst    = 1'b1;
    tx_val = 1'b0;
    @(negedge clk_125);
    checkOutput("rst tx_req", {63'd0, tx_req}, 64'd0);
    checkOutput("rst tx_st", {63'd0, tx_st}, 64'd0);
    checkOutput("rst tx_end", {63'd0, tx_end}, 64'd0);
    checkOutput("rst busy", {63'd0, busy}, 64'd0);
    checkOutput("rst drop_cnt", {56'd0, drop_cnt}, 64'd0);
    rst = 1'b0;
    waitCycles(2);
    sendMrd(32'h10, 10'd1, 8'h31, 16'h0000);
    collectCpl("rst cleared", 2, 64'h4A000001_01000004, 64'h00003110_00000000, 64'd0, 64'd0, 1'b0, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
